// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush performance counters.
package hazard_pkg;

  localparam int unsigned FWD_SEL_W = 2;
  localparam int unsigned PERF_W    = 32;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } hz_state_t;

  localparam logic [FWD_SEL_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_W   = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline register indices/flags in, stall/flush/forward controls out.
// With HAZARD_PERF_CNT_EN defined the bundle also carries StallCount/FlushCount.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                      RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE;
  logic                      StallF, StallD, StallE, FlushD, FlushE, MulDivDoneE;
  logic [1:0]                ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]               StallCount, FlushCount;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, MulDivDoneE,
    input  ForwardAE, ForwardBE
`ifdef HAZARD_PERF_CNT_EN
    , input StallCount, FlushCount
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE,
    output StallF, StallD, StallE, FlushD, FlushE, MulDivDoneE,
    output ForwardAE, ForwardBE
`ifdef HAZARD_PERF_CNT_EN
    , output StallCount, FlushCount
`endif
  );

endinterface

// File: rtl/forward_sel.sv
// Operand forwarding select for one E-stage source register; M-stage result wins over W-stage.
module forward_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output logic [FWD_SEL_W-1:0]      fwd_sel_c_o
);

  always_comb begin
    fwd_sel_c_o = FWD_REG;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_sel_c_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_sel_c_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencing for the 5-stage pipeline, including multi-cycle mul/div occupancy.
// Optional macro HAZARD_PERF_CNT_EN adds StallCount/FlushCount performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MULDIV_CYCLES  = 4,
  parameter int unsigned CNT_WIDTH      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_WIDTH-1:0] CNT_START = CNT_WIDTH'(MULDIV_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  hz_state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stall_f_c, stall_d_c, stall_e_c, flush_d_c, flush_e_c, done_c;
  logic                   load_use_c;
  logic [FWD_SEL_W-1:0]   fwd_a_c, fwd_b_c;

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e_i        (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .rd_w_i        (hz.RdW),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_sel_c_o   (fwd_a_c)
  );

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e_i        (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .rd_w_i        (hz.RdW),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_sel_c_o   (fwd_b_c)
  );

  assign load_use_c = hz.LoadE && (hz.RdE != '0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall/flush controls; branch beats mul/div start beats load-use.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.PCSrcE) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end else if (hz.MulDivStartE && (MULDIV_CYCLES > 1)) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          cnt_d     = CNT_START;
          state_d   = MULDIV;
        end else begin
          if (load_use_c) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
          end
          // Single-cycle configuration: the op completes in its start cycle.
          done_c = hz.MulDivStartE;
        end
      end
      MULDIV: begin
        if (cnt_q > CNT_ONE) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          cnt_d     = cnt_q - CNT_ONE;
        end else begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Controls are forced low while reset is asserted, independent of the clock.
  assign hz.StallF      = rst_n & stall_f_c;
  assign hz.StallD      = rst_n & stall_d_c;
  assign hz.StallE      = rst_n & stall_e_c;
  assign hz.FlushD      = rst_n & flush_d_c;
  assign hz.FlushE      = rst_n & flush_e_c;
  assign hz.MulDivDoneE = rst_n & done_c;
  assign hz.ForwardAE   = rst_n ? fwd_a_c : FWD_REG;
  assign hz.ForwardBE   = rst_n ? fwd_b_c : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f_c) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (flush_e_c) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic vs. a cycle-age model.
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_pipeline_hazard_ctrl;

  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Mul/div age: -1 when no op is in E, otherwise cycles since the op entered E.
  int          md_age = -1;
  int unsigned exp_stalls = 0;
  int unsigned exp_flushes = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) hz ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH (5),
    .MULDIV_CYCLES  (MD),
    .CNT_WIDTH      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic wm, input logic ww);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
    hz.PCSrcE = 1'b0; hz.MulDivStartE = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {29'd0, hz.StallF, hz.StallD, hz.StallE}, 32'd0);
    chk({tag, "_flush"}, {30'd0, hz.FlushD, hz.FlushE}, 32'd0);
    chk({tag, "_fwd"},   {28'd0, hz.ForwardAE, hz.ForwardBE}, 32'd0);
    chk({tag, "_done"},  {31'd0, hz.MulDivDoneE}, 32'd0);
  endtask

  // Called just after a falling edge with inputs applied: checks this cycle, then advances a cycle.
  task automatic step();
    logic sf, sd, se, fd, fe, dn;
    logic starts;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; dn = 0; starts = 0;
    #1;
    if (md_age >= 0) begin
      sf = (md_age < MD - 1); sd = sf; se = sf;
      dn = (md_age == MD - 1);
    end else if (hz.PCSrcE) begin
      fd = 1; fe = 1;
    end else if (hz.MulDivStartE && MD > 1) begin
      sf = 1; sd = 1; se = 1; starts = 1;
    end else begin
      if (hz.LoadE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D)) begin
        sf = 1; sd = 1; fe = 1;
      end
      dn = hz.MulDivStartE;
    end
    chk("StallF", 32'(hz.StallF), 32'(sf));
    chk("StallD", 32'(hz.StallD), 32'(sd));
    chk("StallE", 32'(hz.StallE), 32'(se));
    chk("FlushD", 32'(hz.FlushD), 32'(fd));
    chk("FlushE", 32'(hz.FlushE), 32'(fe));
    chk("MulDivDoneE", 32'(hz.MulDivDoneE), 32'(dn));
    chk("ForwardAE", 32'(hz.ForwardAE),
        32'(fwd_model(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW)));
    chk("ForwardBE", 32'(hz.ForwardBE),
        32'(fwd_model(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW)));
`ifdef HAZARD_PERF_CNT_EN
    chk("StallCount", hz.StallCount, exp_stalls);
    chk("FlushCount", hz.FlushCount, exp_flushes);
`endif
    @(posedge clk);
    if (sf) exp_stalls++;
    if (fe) exp_flushes++;
    if (md_age >= 0) begin
      md_age++;
      if (md_age >= MD) md_age = -1;
    end else if (starts) begin
      md_age = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    // Reset held: outputs must stay low even with hazards and forwarding matches present.
    hz.PCSrcE = 1'b1; hz.RegWriteM = 1'b1; hz.RdM = 5'd3; hz.Rs1E = 5'd3; hz.Rs2E = 5'd3;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset_hold");
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding: M over W, W alone, and register zero never forwards.
    hz.RegWriteM = 1; hz.RdM = 5'd5; hz.RegWriteW = 1; hz.RdW = 5'd5; hz.Rs1E = 5'd5;
    #1 chk("fwd_m_prio", 32'(hz.ForwardAE), 32'h2);
    step();
    hz.RdM = 5'd0;
    #1 chk("fwd_w_only", 32'(hz.ForwardAE), 32'h1);
    step();
    hz.RdW = 5'd0; hz.Rs2E = 5'd0;
    #1 chk("fwd_zero", 32'(hz.ForwardBE), 32'h0);
    step();
    idle_inputs();

    // Load-use bubble for one cycle, then the load has moved on.
    hz.LoadE = 1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1 chk("load_use", {29'd0, hz.StallF, hz.StallD, hz.FlushE}, 32'h7);
    step();
    idle_inputs();
    step();
    hz.LoadE = 1; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
    step();

    // Branch alongside a load-use: redirect wins, no stall.
    hz.LoadE = 1; hz.RdE = 5'd9; hz.Rs1D = 5'd9; hz.PCSrcE = 1;
    #1 chk("branch_vs_lu", {29'd0, hz.FlushD, hz.FlushE, hz.StallF}, 32'h6);
    step();
    idle_inputs();

    // Mul/div occupancy with a branch and load-use pulsed mid-op.
    hz.MulDivStartE = 1;
    step();
    hz.MulDivStartE = 0; hz.PCSrcE = 1; hz.LoadE = 1; hz.RdE = 5'd2; hz.Rs1D = 5'd2;
    step();
    idle_inputs();
    step();
    #1 chk("md_done", 32'(hz.MulDivDoneE), 32'h1);
    step();
    step();

    // Async reset in the middle of a mul/div aborts it immediately.
    hz.MulDivStartE = 1;
    step();
    hz.MulDivStartE = 0;
    step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_async");
    md_age = -1; exp_stalls = 0; exp_flushes = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // One full mul/div followed by one branch.
    hz.MulDivStartE = 1;
    step();
    hz.MulDivStartE = 0;
    repeat (MD - 1) step();
    hz.PCSrcE = 1;
    step();
    hz.PCSrcE = 0;
`ifdef HAZARD_PERF_CNT_EN
    #1;
    chk("perf_stalls", hz.StallCount, 32'd3);
    chk("perf_flushes", hz.FlushCount, 32'd1);
`endif

    // Random traffic on a small register set to provoke frequent matches.
    for (int i = 0; i < 500; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.RegWriteM    = 1'($urandom_range(0, 1));
      hz.RegWriteW    = 1'($urandom_range(0, 1));
      hz.LoadE        = ($urandom_range(0, 2) == 0);
      hz.PCSrcE       = ($urandom_range(0, 7) == 0);
      hz.MulDivStartE = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline (F, D, E, M, W).
- Produces stall, flush and forwarding controls that sequence the F/D, D/E and E/M pipeline registers.
- Handles three hazard classes: load-use stalls, taken branch/jump redirects, and multi-cycle execute (mul/div) occupancy via a counter-driven FSM.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- MULDIV_CYCLES, 4, total cycles a multi-cycle op occupies E; legal range 1..7.
- CNT_WIDTH, 3, occupancy counter width; must satisfy 2^CNT_WIDTH > MULDIV_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source regs of D-stage instr.
- Rs1E, Rs2E  in  REG_ADDR_WIDTH  source regs of E-stage instr.
- RdE, RdM, RdW  in  REG_ADDR_WIDTH  destination regs in E/M/W.
- RegWriteM, RegWriteW  in  1  M/W instr writes register file.
- LoadE  in  1  E-stage instr is a load (ResultSrcE selects memory).
- PCSrcE  in  1  branch/jump taken, resolved in E.
- MulDivStartE  in  1  E-stage instr is a multi-cycle op.
- StallF, StallD, StallE  out  1  hold PC / F-D reg / D-E reg.
- FlushD, FlushE  out  1  clear F-D / D-E reg (insert bubble).
- ForwardAE, ForwardBE  out  2  ALU operand source select.
- MulDivDoneE  out  1  final cycle of multi-cycle op.

Behaviour:
- Reset: while rst_n=0, state=RUN, cnt=0, and all outputs are 0.
- Forwarding (combinational, per operand X in {1,2}):
  - 2'b10 if RegWriteM && RdM!=0 && RdM==RsXE.
  - else 2'b01 if RegWriteW && RdW!=0 && RdW==RsXE.
  - else 2'b00.
  - M has priority over W. Forwarding is active in all states.
- FSM states: RUN, MULDIV.
- RUN, evaluated in priority order:
  1. PCSrcE=1 → FlushD=1, FlushE=1, no stalls; MulDivStartE ignored; stay RUN.
  2. MulDivStartE=1 and MULDIV_CYCLES>1 → StallF=StallD=StallE=1; cnt<=MULDIV_CYCLES-1; go MULDIV.
  3. LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) → StallF=StallD=1, FlushE=1 (one bubble); stay RUN.
  4. Otherwise all controls 0.
  - Rule 2 has priority over rule 3; the load-use check is not made while the mul/div stall is active.
  - MULDIV_CYCLES=1: rule 2 never fires; MulDivDoneE=1 combinationally in the start cycle.
- MULDIV:
  - cnt>1: StallF=StallD=StallE=1; cnt<=cnt-1.
  - cnt==1: all stalls 0; MulDivDoneE=1; cnt<=0; go RUN.
  - PCSrcE, MulDivStartE and load-use are ignored in MULDIV.
  - The op occupies E for exactly MULDIV_CYCLES cycles; stalls are asserted for MULDIV_CYCLES-1 cycles.
- Flushes are never asserted together with StallE.
- Reset asserted mid-MULDIV aborts immediately to RUN; cnt is cleared.
- Only the FSM and counter (plus optional counters) are registered; all controls are combinational from state and inputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs StallCount[31:0] and FlushCount[31:0].
  - StallCount increments each cycle StallF=1.
  - FlushCount increments each cycle FlushE=1.
  - Both reset to 0 on rst_n=0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - typedef enum {RUN, MULDIV} hz_state_t.
  - Constants FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module forward_sel: combinational, one operand; instantiated twice, for A and B.

Test Plan:
- Reset: rst_n=0 mid-run → all outputs 0 and state RUN within the same cycle, asynchronously.
- Forwarding: RegWriteM=1, RdM=5; RegWriteW=1, RdW=5; Rs1E=5 → ForwardAE=2'b10. Same with RdM=0 → 2'b01. Rs2E=0 with RdW=0 → ForwardBE=2'b00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 → exactly one cycle of StallF=StallD=FlushE=1. RdE=0 → no stall.
- Branch: PCSrcE=1 with a simultaneous load-use → FlushD=FlushE=1, StallF=0.
- Mul/div, MULDIV_CYCLES=4: MulDivStartE=1 → StallE high for 3 cycles, then MulDivDoneE=1 for 1 cycle. PCSrcE pulsed during MULDIV → no flush.
- HAZARD_PERF_CNT_EN: after one 4-cycle mul and one branch → StallCount=3, FlushCount=1.
